// File: rtl/fir_coef_ctrl.sv
// fir_coef_ctrl
//   Coefficient bank and sequencing controller for the shared FIR on the ADC
//   sample path. Software writes coefficients into a shadow bank. A commit
//   request copies the shadow bank into the active bank. The copy happens
//   only on a sample strobe, so the FIR never sees a mixed coefficient set.
//   After each swap the controller counts strobes until the FIR pipeline holds
//   only samples processed with the new set, and then raises out_valid.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   coef_we    shadow write strobe (one word per cycle)
//   coef_addr  tap index to write (0 = tap[0], newest sample)
//   coef_data  coefficient value (signed, stored as raw bits)
//   commit     one-cycle request to swap shadow -> active
//   rd_addr    shadow readback address
//   rd_data    registered shadow readback (0 for out-of-range address)
//   in_stb     new ADC sample present (single-cycle pulse)
//   fir_tick   FIR clock enable, in_stb delayed by one cycle
//   coefs      active bank, tap i in [(TAPS-1-i)*32 +: 32], zero-extended
//   out_valid  FIR output was computed entirely with the current active set
//   busy       swap pending or pipeline still filling
//   addr_err   sticky flag for a write to an address >= TAPS
//   err_clr    clears addr_err (a bad write in the same cycle wins)
module fir_coef_ctrl #(
  parameter int TAPS   = 5,
  parameter int CWIDTH = 16,
  localparam int AW    = (TAPS > 2) ? $clog2(TAPS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                coef_we,
  input  logic [AW-1:0]       coef_addr,
  input  logic [CWIDTH-1:0]   coef_data,
  input  logic                commit,
  input  logic [AW-1:0]       rd_addr,
  output logic [CWIDTH-1:0]   rd_data,
  input  logic                in_stb,
  output logic                fir_tick,
  output logic [TAPS*32-1:0]  coefs,
  output logic                out_valid,
  output logic                busy,
  output logic                addr_err,
  input  logic                err_clr
);

  localparam int FILL_LEN = TAPS + 3;
  localparam int CNTW     = $clog2(FILL_LEN + 1);
  localparam logic [AW:0]     TAPS_L = (AW+1)'(TAPS);
  // Count value held on the strobe just before the last fill strobe.
  localparam logic [CNTW-1:0] RUN_AT = CNTW'(FILL_LEN - 2);

  typedef enum logic [1:0] {NOCFG, PEND, FILL, RUN} state_t;

  state_t state_reg, state_next;

  logic [CWIDTH-1:0] shadow_reg [TAPS];
  logic [CWIDTH-1:0] active_reg [TAPS];

  logic [CWIDTH-1:0] rd_data_reg;
  logic [CWIDTH-1:0] rd_word;
  logic [CNTW-1:0]   fill_cnt_reg, fill_cnt_next;
  logic              out_valid_reg, out_valid_next;
  logic              busy_reg, busy_next;
  logic              fir_tick_reg;
  logic              addr_err_reg;

  logic wr_ok, wr_bad, rd_ok, swap;

  assign wr_ok  = coef_we && ({1'b0, coef_addr} < TAPS_L);
  assign wr_bad = coef_we && !({1'b0, coef_addr} < TAPS_L);
  assign rd_ok  = ({1'b0, rd_addr} < TAPS_L);

  // A swap needs a sample strobe plus either an earlier commit (PEND) or a
  // commit arriving in the same cycle as the strobe.
  assign swap = in_stb && ((state_reg == PEND) || commit);

  // Shadow and active banks, one register word per tap. The active copy
  // takes the shadow value from before any write in the same cycle.
  generate
    for (genvar gi = 0; gi < TAPS; gi++) begin : g_tap
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          shadow_reg[gi] <= '0;
        end else if (wr_ok && (coef_addr == AW'(gi))) begin
          shadow_reg[gi] <= coef_data;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          active_reg[gi] <= '0;
        end else if (swap) begin
          active_reg[gi] <= shadow_reg[gi];
        end
      end

      assign coefs[(TAPS-1-gi)*32 +: 32] = 32'(active_reg[gi]);
    end
  endgenerate

  always_comb begin
    rd_word = '0;
    if (rd_ok) begin
      rd_word = shadow_reg[rd_addr];
    end
  end

  // State register together with the registered FSM outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= NOCFG;
      fill_cnt_reg  <= '0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      fill_cnt_reg  <= fill_cnt_next;
      out_valid_reg <= out_valid_next;
      busy_reg      <= busy_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    if (swap) begin
      state_next = FILL;
    end else if (commit) begin
      // From NOCFG, FILL or RUN a commit waits for the next strobe;
      // in PEND it is simply absorbed.
      state_next = PEND;
    end else begin
      case (state_reg)
        FILL:    if (in_stb && (fill_cnt_reg == RUN_AT)) state_next = RUN;
        default: state_next = state_reg;
      endcase
    end
  end

  // Output / datapath-control logic.
  always_comb begin
    fill_cnt_next  = fill_cnt_reg;
    out_valid_next = out_valid_reg;
    if (swap) begin
      fill_cnt_next  = '0;
      out_valid_next = 1'b0;
    end else if ((state_reg == FILL) && !commit && in_stb) begin
      if (fill_cnt_reg != '1) begin
        fill_cnt_next = fill_cnt_reg + CNTW'(1);
      end
      if (fill_cnt_reg == RUN_AT) begin
        out_valid_next = 1'b1;
      end
    end
    busy_next = (state_next == PEND) || (state_next == FILL);
  end

  // Tick, readback and error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fir_tick_reg <= 1'b0;
      rd_data_reg  <= '0;
      addr_err_reg <= 1'b0;
    end else begin
      fir_tick_reg <= in_stb;
      rd_data_reg  <= rd_word;
      if (wr_bad) begin
        addr_err_reg <= 1'b1;
      end else if (err_clr) begin
        addr_err_reg <= 1'b0;
      end
    end
  end

  assign rd_data   = rd_data_reg;
  assign fir_tick  = fir_tick_reg;
  assign out_valid = out_valid_reg;
  assign busy      = busy_reg;
  assign addr_err  = addr_err_reg;

endmodule

// File: tb/tb_fir_coef_ctrl.sv
// Testbench for fir_coef_ctrl: directed table, hand-written corner sequences
// and a randomized run, all checked against a behavioural model.
module tb_fir_coef_ctrl;

  localparam int TAPS     = 5;
  localparam int CWIDTH   = 16;
  localparam int AW       = 3;
  localparam int FILL_LEN = TAPS + 3;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                coef_we = 1'b0;
  logic [AW-1:0]       coef_addr = '0;
  logic [CWIDTH-1:0]   coef_data = '0;
  logic                commit = 1'b0;
  logic [AW-1:0]       rd_addr = '0;
  logic [CWIDTH-1:0]   rd_data;
  logic                in_stb = 1'b0;
  logic                fir_tick;
  logic [TAPS*32-1:0]  coefs;
  logic                out_valid;
  logic                busy;
  logic                addr_err;
  logic                err_clr = 1'b0;

  fir_coef_ctrl #(.TAPS(TAPS), .CWIDTH(CWIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .commit(commit), .rd_addr(rd_addr),
    .rd_data(rd_data), .in_stb(in_stb), .fir_tick(fir_tick), .coefs(coefs),
    .out_valid(out_valid), .busy(busy), .addr_err(addr_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Behavioural model: banks as arrays, sequencing as "swap pending" and
  // "strobes seen since the last swap".
  logic [CWIDTH-1:0] m_shadow [TAPS];
  logic [CWIDTH-1:0] m_active [TAPS];
  logic [CWIDTH-1:0] m_rd;
  bit m_pending, m_counting, m_valid, m_err, m_tick;
  int m_strobes;

  function automatic void model_reset();
    for (int i = 0; i < TAPS; i++) begin
      m_shadow[i] = '0;
      m_active[i] = '0;
    end
    m_rd = '0;
    m_pending = 0; m_counting = 0; m_valid = 0; m_err = 0; m_tick = 0;
    m_strobes = 0;
  endfunction

  function automatic void model_edge();
    logic [CWIDTH-1:0] old_sh [TAPS];
    bit do_swap;
    old_sh = m_shadow;
    m_rd   = (rd_addr < 3'd5) ? old_sh[rd_addr] : '0;
    m_tick = in_stb;
    if (coef_we && coef_addr < 3'd5) m_shadow[coef_addr] = coef_data;
    if (coef_we && coef_addr >= 3'd5) m_err = 1;
    else if (err_clr) m_err = 0;
    do_swap = in_stb && (m_pending || commit);
    if (do_swap) begin
      m_active   = old_sh;
      m_pending  = 0;
      m_counting = 1;
      m_strobes  = 1;
      m_valid    = 0;
    end else if (commit) begin
      m_pending  = 1;
      m_counting = 0;
    end else if (in_stb && m_counting) begin
      m_strobes++;
      if (m_strobes == FILL_LEN) begin
        m_valid    = 1;
        m_counting = 0;
      end
    end
  endfunction

  function automatic logic [TAPS*32-1:0] model_coefs();
    logic [TAPS*32-1:0] v;
    for (int i = 0; i < TAPS; i++) v[(TAPS-1-i)*32 +: 32] = {16'd0, m_active[i]};
    return v;
  endfunction

  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(string tag);
    logic [179:0] act, exp;
    act = {coefs, rd_data, fir_tick, out_valid, busy, addr_err};
    exp = {model_coefs(), m_rd, m_tick, m_valid, m_pending || m_counting, m_err};
    chk(tag, 256'(act), 256'(exp));
  endtask

  // One clock: DUT and model see the same inputs, outputs checked #1 later,
  // then back to the falling edge where pulse inputs are dropped.
  task automatic cyc(string tag = "model");
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check_all(tag);
    @(negedge clk);
    coef_we = 1'b0; commit = 1'b0; in_stb = 1'b0; err_clr = 1'b0;
  endtask

  // One sample strobe followed by three quiet cycles (strobe every 4 clk).
  task automatic strobe();
    in_stb = 1'b1;
    cyc("model_stb");
    repeat (3) cyc("model_gap");
  endtask

  typedef struct {
    bit            we;
    logic [2:0]    addr;
    logic [15:0]   data;
    bit            clr;
    bit            cmt;
    logic [2:0]    ra;
    logic [15:0]   exp_rd;
    bit            exp_err;
  } vec_t;

  vec_t tbl [12];
  logic [159:0] exp1, exp6;
  bit prev_stb;

  initial begin
    // Writes, readback, bad addresses and sticky error behaviour.
    tbl[0]  = '{1'b1, 3'd0, 16'd1342, 1'b0, 1'b0, 3'd0, 16'd0,    1'b0};
    tbl[1]  = '{1'b1, 3'd4, 16'd1342, 1'b0, 1'b0, 3'd0, 16'd1342, 1'b0};
    tbl[2]  = '{1'b1, 3'd1, 16'd21,   1'b0, 1'b0, 3'd4, 16'd1342, 1'b0};
    tbl[3]  = '{1'b1, 3'd2, 16'd21,   1'b0, 1'b0, 3'd1, 16'd21,   1'b0};
    tbl[4]  = '{1'b1, 3'd3, 16'd21,   1'b0, 1'b0, 3'd2, 16'd21,   1'b0};
    tbl[5]  = '{1'b1, 3'd6, 16'd999,  1'b0, 1'b0, 3'd3, 16'd21,   1'b1};
    tbl[6]  = '{1'b0, 3'd0, 16'd0,    1'b0, 1'b1, 3'd6, 16'd0,    1'b1};
    tbl[7]  = '{1'b0, 3'd0, 16'd0,    1'b1, 1'b0, 3'd4, 16'd1342, 1'b0};
    tbl[8]  = '{1'b1, 3'd7, 16'd55,   1'b1, 1'b0, 3'd0, 16'd1342, 1'b1};
    tbl[9]  = '{1'b0, 3'd0, 16'd0,    1'b1, 1'b0, 3'd2, 16'd21,   1'b0};
    tbl[10] = '{1'b1, 3'd5, 16'd77,   1'b0, 1'b0, 3'd5, 16'd0,    1'b1};
    tbl[11] = '{1'b0, 3'd0, 16'd0,    1'b1, 1'b0, 3'd0, 16'd1342, 1'b0};
    exp1 = {32'd1342, 32'd21, 32'd21, 32'd21, 32'd1342};
    exp6 = {32'd100, 32'd101, 32'd102, 32'd103, 32'd104};

    // Reset state
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 256'({coefs, rd_data, fir_tick, out_valid, busy, addr_err}), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 12; i++) begin
      coef_we = tbl[i].we; coef_addr = tbl[i].addr; coef_data = tbl[i].data;
      err_clr = tbl[i].clr; commit = tbl[i].cmt; rd_addr = tbl[i].ra;
      cyc("model_tbl");
      chk("tbl_rd_data", 256'(rd_data), 256'(tbl[i].exp_rd));
      chk("tbl_addr_err", 256'(addr_err), 256'(tbl[i].exp_err));
      $display("[TB] vec %0d we=%0b addr=%0d data=%0d clr=%0b cmt=%0b rd=%0d err=%0b",
               i, tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].clr, tbl[i].cmt, rd_data, addr_err);
    end

    // Commit then strobes: swap at 1st strobe, valid after 8th.
    commit = 1'b1;
    cyc("model_commit");
    strobe();
    chk("swap_coefs", 256'(coefs), 256'(exp1));
    chk("swap_busy", 256'(busy), 256'(1));
    for (int k = 2; k <= FILL_LEN - 1; k++) strobe();
    chk("fill_valid_low", 256'(out_valid), 256'(0));
    strobe();
    chk("fill_valid_high", 256'(out_valid), 256'(1));
    $display("[TB] first swap done, out_valid=%0b", out_valid);

    // Reconfigure in RUN between strobes.
    coef_we = 1'b1; coef_addr = 3'd2; coef_data = 16'd500;
    cyc("model_wr");
    commit = 1'b1;
    cyc("model_commit");
    cyc("model_gap");
    chk("run_commit_coefs", 256'(coefs), 256'(exp1));
    chk("run_commit_valid", 256'(out_valid), 256'(1));
    strobe();
    chk("reswap_tap2", 256'(coefs[95:64]), 256'(500));
    chk("reswap_valid", 256'(out_valid), 256'(0));
    for (int k = 2; k <= FILL_LEN - 1; k++) strobe();
    chk("refill_valid_low", 256'(out_valid), 256'(0));
    strobe();
    chk("refill_valid_high", 256'(out_valid), 256'(1));
    $display("[TB] second swap done, out_valid=%0b", out_valid);

    // commit + in_stb + write tap0 all in one cycle.
    commit = 1'b1; in_stb = 1'b1; coef_we = 1'b1; coef_addr = 3'd0; coef_data = 16'd7;
    cyc("model_same");
    chk("same_cycle_tap0", 256'(coefs[159:128]), 256'(1342));
    rd_addr = 3'd0;
    cyc("model_rd");
    chk("same_cycle_rd", 256'(rd_data), 256'(7));
    repeat (2) cyc("model_gap");

    // Async reset in FILL after 3 strobes total.
    strobe();
    strobe();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", 256'({coefs, rd_data, fir_tick, out_valid, busy, addr_err}), 256'(0));
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) strobe();
    chk("no_commit_valid", 256'(out_valid), 256'(0));
    $display("[TB] reset in fill done, out_valid=%0b busy=%0b", out_valid, busy);

    // Three commits in PEND, then one strobe: one swap.
    for (int i = 0; i < TAPS; i++) begin
      coef_we = 1'b1; coef_addr = 3'(i); coef_data = 16'(100 + i);
      cyc("model_wr");
    end
    repeat (3) begin
      commit = 1'b1;
      cyc("model_commit");
    end
    strobe();
    chk("multi_commit_coefs", 256'(coefs), 256'(exp6));
    chk("multi_commit_busy", 256'(busy), 256'(1));
    for (int k = 2; k <= FILL_LEN - 1; k++) strobe();
    chk("multi_valid_low", 256'(out_valid), 256'(0));
    strobe();
    chk("multi_valid_high", 256'(out_valid), 256'(1));
    $display("[TB] multi-commit swap done, out_valid=%0b", out_valid);

    // Randomized run against the model.
    prev_stb = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      in_stb    = prev_stb ? 1'b0 : ($urandom_range(0, 2) == 0);
      prev_stb  = in_stb;
      commit    = ($urandom_range(0, 19) == 0);
      coef_we   = ($urandom_range(0, 3) == 0);
      coef_addr = 3'($urandom_range(0, 7));
      coef_data = 16'($urandom);
      err_clr   = ($urandom_range(0, 9) == 0);
      rd_addr   = 3'($urandom_range(0, 7));
      if (in_stb)
        $display("[TB] rand stb %0d commit=%0b", n, commit);
      cyc("model_rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
